// File: rtl/class_wrr_scheduler_pkg.sv
// Shared types and constants for the class weighted round-robin scheduler
// and its reusable circular arbiter.
package class_wrr_scheduler_pkg;

  localparam int WINDOW_LOG2_DEF = 14;
  localparam int QUOTA_WIDTH_DEF = 32;
  localparam int CLASS_IDX_W     = 5;

  // A quota with every bit set means the class is never throttled.
  localparam logic QUOTA_UNL_FILL = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } sched_state_e;

endpackage

// File: rtl/class_wrr_scheduler_rr_arbiter.sv
// Combinational circular-priority pick: first set request at or after ptr wins.
// Shared between the RX scheduler and the TX path.
module class_wrr_scheduler_rr_arbiter
  import class_wrr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  int idx;

  // Walk from the farthest offset back to ptr so the closest request wins last.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IDX_W'(idx);
        gnt_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/class_wrr_scheduler.sv
// Packet-granular weighted round-robin scheduler merging per-class AXI-stream
// queues onto one RX datapath, with per-window beat quotas per class.
//   state | meaning
//   IDLE  | no owner; pick next eligible class from the RR pointer
//   XFER  | owner's stream passed through until its tlast beat is accepted
module class_wrr_scheduler
  import class_wrr_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_CLASS   = 5,
  parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int QUOTA_WIDTH = QUOTA_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLASS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CLASS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [NUM_CLASS-1:0]              s_axis_tvalid,
  input  logic [NUM_CLASS-1:0]              s_axis_tlast,
  output logic [NUM_CLASS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [CLASS_IDX_W-1:0]            m_flow_class,
  input  logic                              cfg_enable,
  input  logic [NUM_CLASS*QUOTA_WIDTH-1:0]  cfg_quota,
  output logic                              stat_window_tick,
  output logic                              stat_busy
);

  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [QUOTA_WIDTH-1:0] QUOTA_UNL = {QUOTA_WIDTH{QUOTA_UNL_FILL}};
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST  = '1;

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WINDOW_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [QUOTA_WIDTH-1:0]   credit_q [NUM_CLASS];
  logic [QUOTA_WIDTH-1:0]   credit_d [NUM_CLASS];
  logic [QUOTA_WIDTH-1:0]   credit_base [NUM_CLASS];
  logic [QUOTA_WIDTH-1:0]   quota [NUM_CLASS];
  logic [NUM_CLASS-1:0]     eligible;
  logic [NUM_CLASS-1:0]     gnt_oh_unused;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     gnt_vld;
  logic                     xfer;
  logic                     beat;
  logic                     tick;

  class_wrr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_CLASS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_oh  (gnt_oh_unused),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    xfer          = (state_q == ST_XFER);
    m_axis_tdata  = s_axis_tdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tkeep  = s_axis_tkeep[int'(owner_q)*KEEP_WIDTH +: KEEP_WIDTH];
    m_axis_tvalid = xfer & s_axis_tvalid[owner_q];
    m_axis_tlast  = xfer & s_axis_tlast[owner_q];
    m_flow_class  = xfer ? CLASS_IDX_W'(owner_q) : '0;
    s_axis_tready = '0;
    if (xfer) s_axis_tready[owner_q] = m_axis_tready;
    beat             = m_axis_tvalid & m_axis_tready;
    tick             = (win_cnt_q == WIN_LAST);
    stat_window_tick = tick;
    stat_busy        = xfer;
    win_cnt_d        = win_cnt_q + 1'b1;
  end

  // Window reload happens first, then the owner's beat is charged against it.
  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      quota[i]       = cfg_quota[i*QUOTA_WIDTH +: QUOTA_WIDTH];
      credit_base[i] = tick ? quota[i] : credit_q[i];
      credit_d[i]    = credit_base[i];
      if (beat && (owner_q == IDX_W'(i)) && (quota[i] != QUOTA_UNL) && (credit_base[i] != '0))
        credit_d[i] = credit_base[i] - 1'b1;
      eligible[i] = s_axis_tvalid[i] && (credit_q[i] != '0) && cfg_enable;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d  = ST_XFER;
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == IDX_W'(NUM_CLASS - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_XFER: begin
        if (beat && m_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      win_cnt_q <= '0;
      for (int i = 0; i < NUM_CLASS; i++) credit_q[i] <= quota[i];
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      win_cnt_q <= win_cnt_d;
      for (int i = 0; i < NUM_CLASS; i++) credit_q[i] <= credit_d[i];
    end
  end

endmodule

// File: tb/tb_class_wrr_scheduler.sv
// Self-checking bench for class_wrr_scheduler: per-cycle reference model of the
// windowed quota / round-robin rules, plus directed scenarios with literal expectations.
module tb_class_wrr_scheduler;

  localparam int DW  = 16;
  localparam int KW  = 2;
  localparam int N   = 5;
  localparam int WL  = 6;
  localparam int QW  = 32;
  localparam int WIN = 1 << WL;
  localparam longint UNL = 64'h0000_0000_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast, m_tready;
  logic [4:0]      m_class;
  logic            cfg_enable;
  logic [N*QW-1:0] cfg_quota;
  logic            tick, busy;

  always #5 clk = ~clk;

  class_wrr_scheduler #(
    .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .NUM_CLASS (N),
    .WINDOW_LOG2 (WL), .QUOTA_WIDTH (QW)
  ) dut (
    .clk (clk), .rst (rst),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (s_tvalid),
    .s_axis_tlast (s_tlast), .s_axis_tready (s_tready),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tvalid (m_tvalid),
    .m_axis_tlast (m_tlast), .m_axis_tready (m_tready), .m_flow_class (m_class),
    .cfg_enable (cfg_enable), .cfg_quota (cfg_quota),
    .stat_window_tick (tick), .stat_busy (busy)
  );

  int n_tests, n_fail, cyc;
  bit chk_en;
  // reference model
  longint quota [N];
  longint credit [N];
  bit     mdl_busy;
  int     mdl_owner, mdl_ptr, mdl_win;
  // sources
  bit src_on [N];
  int src_pkts [N], src_len_fix [N], cur_len [N], beat_i [N], seq [N];
  bit pres [N], acc [N];
  int bubble_pct, bp_pct;
  bit ctl_rst, ctl_en;
  // observations taken from the DUT outputs
  int obs_beats [N], win_beats [N], last_win [N];
  int win_snaps, first_beat_cyc, last_beat_cyc;
  int order_q [$];
  longint snap_tvalid, snap_tready, snap_class, snap_busy, snap_tick, snap_tlast;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int new_len(input int i);
    return (src_len_fix[i] != 0) ? src_len_fix[i] : int'($urandom_range(4, 1));
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && src_on[i] && src_pkts[i] != 0 && int'($urandom_range(99)) >= bubble_pct)
        pres[i] = 1'b1;
      s_tvalid[i]          = pres[i];
      s_tdata[i*DW +: DW]  = {4'(i), 12'(seq[i])};
      s_tkeep[i*KW +: KW]  = 2'(seq[i] + i);
      s_tlast[i]           = (beat_i[i] == cur_len[i] - 1);
      cfg_quota[i*QW +: QW] = quota[i][QW-1:0];
    end
    rst        = ctl_rst;
    cfg_enable = ctl_en;
    m_tready   = (int'($urandom_range(99)) >= bp_pct);
  endtask

  task automatic src_advance();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pres[i] = 1'b0;
        seq[i]++;
        if (beat_i[i] == cur_len[i] - 1) begin
          beat_i[i]  = 0;
          cur_len[i] = new_len(i);
          if (src_pkts[i] > 0) src_pkts[i]--;
        end else begin
          beat_i[i]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_win = 0;
    for (int i = 0; i < N; i++) credit[i] = quota[i];
  endtask

  task automatic compare_and_model();
    int o, pick;
    bit exp_valid, m_beat, is_tick;
    longint exp_ready;
    o         = mdl_owner;
    exp_valid = mdl_busy && s_tvalid[o];
    exp_ready = (mdl_busy && m_tready) ? (longint'(1) << o) : 0;
    is_tick   = (mdl_win == WIN - 1);
    if (chk_en) begin
      check("m_tvalid", m_tvalid, exp_valid);
      check("s_tready", s_tready, exp_ready);
      check("flow_class", m_class, mdl_busy ? o : 0);
      check("stat_busy", busy, mdl_busy);
      check("window_tick", tick, is_tick);
      if (exp_valid) begin
        check("m_tdata", m_tdata, s_tdata[o*DW +: DW]);
        check("m_tkeep", m_tkeep, s_tkeep[o*KW +: KW]);
        check("m_tlast", m_tlast, s_tlast[o]);
      end
      if (!mdl_busy) check("m_tlast_idle", m_tlast, 0);
    end
    snap_tvalid = m_tvalid; snap_tready = s_tready; snap_class = m_class;
    snap_busy = busy; snap_tick = tick; snap_tlast = m_tlast;
    if (m_tvalid && m_tready && m_class < N) begin
      obs_beats[m_class]++;
      win_beats[m_class]++;
      order_q.push_back(int'(m_class));
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      if (m_tlast) last_beat_cyc = cyc;
    end
    if (is_tick) begin
      for (int i = 0; i < N; i++) begin last_win[i] = win_beats[i]; win_beats[i] = 0; end
      win_snaps++;
    end
    for (int i = 0; i < N; i++) acc[i] = s_tvalid[i] && s_tready[i];
    // advance the model: grant decision uses this cycle's credits
    m_beat = mdl_busy && s_tvalid[o] && m_tready;
    if (mdl_busy) begin
      if (m_beat && s_tlast[o]) mdl_busy = 1'b0;
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (pick < 0 && s_tvalid[c] && credit[c] != 0 && ctl_en) pick = c;
      end
      if (pick >= 0) begin
        mdl_busy = 1'b1; mdl_owner = pick; mdl_ptr = (pick + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (is_tick) credit[i] = quota[i];
      if (m_beat && i == o && quota[i] != UNL && credit[i] > 0) credit[i]--;
    end
    mdl_win = (mdl_win + 1) % WIN;
    if (ctl_rst) model_reset();
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    compare_and_model();
    @(posedge clk);
    #1;
    src_advance();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin obs_beats[i] = 0; win_beats[i] = 0; last_win[i] = 0; end
    win_snaps = 0; first_beat_cyc = -1; last_beat_cyc = -1;
    order_q.delete();
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) begin src_on[i] = 1'b0; pres[i] = 1'b0; beat_i[i] = 0; end
    ctl_rst = 1'b1; step(); step(); ctl_rst = 1'b0;
  endtask

  task automatic src_cfg(input int i, input int len, input int pkts);
    src_on[i] = 1'b1; src_len_fix[i] = len; src_pkts[i] = pkts;
    cur_len[i] = new_len(i); beat_i[i] = 0; pres[i] = 1'b0;
  endtask

  initial begin
    int start;
    n_tests = 0; n_fail = 0; cyc = 0; chk_en = 1'b0;
    bubble_pct = 0; bp_pct = 0; ctl_en = 1'b1; ctl_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      quota[i] = UNL; src_on[i] = 1'b0; src_pkts[i] = 0; src_len_fix[i] = 1;
      cur_len[i] = 1; beat_i[i] = 0; seq[i] = 0; pres[i] = 1'b0; acc[i] = 1'b0;
    end
    clear_obs();
    @(posedge clk); #1;
    drive();
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;

    // reset state
    step();
    check("rst_tvalid", snap_tvalid, 0);
    check("rst_tready", snap_tready, 0);
    check("rst_class", snap_class, 0);
    check("rst_busy", snap_busy, 0);
    check("rst_tick", snap_tick, 0);
    check("rst_tlast", snap_tlast, 0);

    // single class 2, 4-beat packet, no backpressure
    reset_all();
    src_cfg(2, 4, 1);
    clear_obs();
    start = cyc;
    repeat (10) step();
    check("p1_beats_c2", obs_beats[2], 4);
    check("p1_beats_total", obs_beats[0] + obs_beats[1] + obs_beats[3] + obs_beats[4], 0);
    check("p1_grant_latency", first_beat_cyc - start, 1);
    check("p1_tlast_beat4", last_beat_cyc - start, 4);

    // three backlogged classes, unlimited quota, 1-beat packets
    reset_all();
    for (int i = 0; i < 3; i++) src_cfg(i, 1, -1);
    clear_obs();
    repeat (14) step();
    check("p2_enough_grants", order_q.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (k < order_q.size()) check("p2_rr_order", order_q[k], k % 3);
    check("p2_bubble_spacing", last_beat_cyc - first_beat_cyc, 2 * (order_q.size() - 1));

    // weighted quotas 2:1 per window
    quota[0] = 2; quota[1] = 1; quota[2] = 0; quota[3] = 0; quota[4] = 0;
    reset_all();
    src_cfg(0, 1, -1); src_cfg(1, 1, -1);
    clear_obs();
    for (int w = 0; w < 3; w++) begin
      repeat (WIN) step();
      check("p3_win_c0", last_win[0], 2);
      check("p3_win_c1", last_win[1], 1);
      check("p3_win_count", win_snaps, w + 1);
    end

    // quota 1 still lets a whole 3-beat packet through once per window
    quota[0] = 1; quota[1] = 0;
    reset_all();
    src_cfg(0, 3, -1);
    clear_obs();
    for (int w = 0; w < 2; w++) begin
      repeat (WIN) step();
      check("p4_win_c0", last_win[0], 3);
    end

    // reset on beat 2 of a 4-beat packet
    for (int i = 0; i < N; i++) quota[i] = UNL;
    reset_all();
    src_cfg(0, 4, -1); src_cfg(1, 4, -1);
    clear_obs();
    step(); step();
    ctl_rst = 1'b1; step(); ctl_rst = 1'b0;
    clear_obs();
    step();
    check("p5_tready_after_rst", snap_tready, 0);
    check("p5_tvalid_after_rst", snap_tvalid, 0);
    check("p5_busy_after_rst", snap_busy, 0);
    repeat (8) step();
    check("p5_has_grant", order_q.size() > 0, 1);
    if (order_q.size() > 0) check("p5_first_grant_c0", order_q[0], 0);

    // randomized quotas, backpressure, source bubbles and enable drops
    bubble_pct = 20; bp_pct = 30;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(5))
          0: quota[i] = 0;
          1: quota[i] = 1;
          2: quota[i] = 2;
          3: quota[i] = 3;
          4: quota[i] = 6;
          default: quota[i] = UNL;
        endcase
      end
      reset_all();
      for (int i = 0; i < N; i++) src_cfg(i, 0, -1);
      repeat (600) begin
        ctl_en = (int'($urandom_range(99)) >= 5);
        step();
      end
      ctl_en = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
